// File: rtl/ks_exciter_feedback.sv
// Karplus-Strong voice controller. It sits at the far end of a 16-bit delay line.
// On pluck it writes a burst of LFSR noise into the line. It then closes the loop
// with a decaying two-tap average of the delayed sample. After a long enough run of
// near-silent feedback it returns to idle.
module ks_exciter_feedback #(
    parameter int          BURST_LEN   = 512,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int          NOISE_SHIFT = 1,
    parameter int          SILENCE_THR = 16,
    parameter int          SILENCE_LEN = 1024
) (
    input  logic        a_clk,
    input  logic        reset_n,
    input  logic        sample_en,
    input  logic        pluck,
    input  logic        mute,
    input  logic [7:0]  decay,
    input  logic [15:0] q,
    output logic [15:0] dnoise,
    output logic [15:0] dfilter,
    output logic        trigger,
    output logic        sclr,
    output logic        busy,
    output logic [15:0] audio_out
);

    localparam int          CNT_W      = $clog2(BURST_LEN);
    localparam int          SIL_W      = $clog2(SILENCE_LEN + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [SIL_W-1:0] SIL_MAX    = SIL_W'(SILENCE_LEN);
    localparam logic [16:0]      THR        = 17'(SILENCE_THR);
    localparam logic [15:0]      LFSR_POLY  = 16'hB400;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_EXCITE = 2'd2,
        ST_RING   = 2'd3
    } state_t;

    // One right-shift step of the Galois LFSR, feedback taken from the bit shifted out.
    function automatic logic [15:0] galois_step(input logic [15:0] v);
        logic [15:0] shifted;
        shifted = {1'b0, v[15:1]};
        if (v[0]) begin
            return shifted ^ LFSR_POLY;
        end else begin
            return shifted;
        end
    endfunction

    // Magnitude in 17 bits so that -32768 does not wrap.
    function automatic logic [16:0] mag17(input logic [15:0] v);
        logic [16:0] ext;
        ext = {v[15], v};
        if (v[15]) begin
            return 17'd0 - ext;
        end else begin
            return ext;
        end
    endfunction

    state_t             state_r, state_next_s;
    logic [CNT_W-1:0]   burst_cnt_r;
    logic [SIL_W-1:0]   sil_cnt_r;
    logic [15:0]        lfsr_r, lfsr_next_s;
    logic signed [15:0] noise_s;
    logic [15:0]        q_prev_r;
    logic signed [16:0] sum_s, avg_s;
    logic signed [8:0]  gain_s;
    logic signed [24:0] prod_s;
    logic               prod_unused_s;
    logic               silent_s;
    logic [15:0]        dnoise_r, dfilter_r, audio_r;
    logic               trigger_r, sclr_r, busy_r;

    // Next-state decode: mute beats pluck, and pluck beats the internal transitions.
    always_comb begin
        state_next_s = state_r;
        if (mute) begin
            state_next_s = ST_CLEAR;
        end else begin
            case (state_r)
                ST_CLEAR:  state_next_s = ST_IDLE;
                ST_IDLE: begin
                    if (pluck) state_next_s = ST_EXCITE;
                    else       state_next_s = ST_IDLE;
                end
                ST_EXCITE: begin
                    if (pluck)                                        state_next_s = ST_EXCITE;
                    else if (sample_en && (burst_cnt_r == BURST_LAST)) state_next_s = ST_RING;
                    else                                              state_next_s = ST_EXCITE;
                end
                ST_RING: begin
                    if (pluck)                      state_next_s = ST_EXCITE;
                    else if (sil_cnt_r == SIL_MAX)  state_next_s = ST_IDLE;
                    else                            state_next_s = ST_RING;
                end
                default:   state_next_s = ST_CLEAR;
            endcase
        end
    end

    // Datapath: the LFSR step, noise scaling, the two-tap average with gain, and the silence test.
    always_comb begin
        lfsr_next_s   = galois_step(lfsr_r);
        noise_s       = $signed(lfsr_next_s) >>> NOISE_SHIFT;
        sum_s         = {q[15], q} + {q_prev_r[15], q_prev_r};
        avg_s         = sum_s >>> 1;
        gain_s        = {1'b0, decay};
        prod_s        = avg_s * gain_s;
        prod_unused_s = ^{prod_s[24], prod_s[7:0]};
        silent_s      = (mag17(dfilter_r) < THR);
    end

    // State register.
    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n) state_r <= ST_CLEAR;
        else          state_r <= state_next_s;
    end

    // Control outputs: trigger and busy follow the new state; sclr pulses the cycle after CLEAR.
    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n) begin
            trigger_r <= 1'b1;
            busy_r    <= 1'b0;
            sclr_r    <= 1'b0;
        end else begin
            trigger_r <= (state_next_s != ST_EXCITE);
            busy_r    <= (state_next_s == ST_EXCITE) || (state_next_s == ST_RING);
            sclr_r    <= (state_r == ST_CLEAR);
        end
    end

    // Burst counter: held at zero outside EXCITE, and restarted by a re-pluck.
    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n)                  burst_cnt_r <= '0;
        else if (state_r != ST_EXCITE) burst_cnt_r <= '0;
        else if (pluck)                burst_cnt_r <= '0;
        else if (sample_en)            burst_cnt_r <= burst_cnt_r + CNT_W'(1);
        else                           burst_cnt_r <= burst_cnt_r;
    end

    // The LFSR and the noise sample advance only on strobes during EXCITE. A re-pluck does not reseed.
    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_r   <= LFSR_SEED;
            dnoise_r <= 16'd0;
        end else if (sample_en && (state_r == ST_EXCITE)) begin
            lfsr_r   <= lfsr_next_s;
            dnoise_r <= noise_s;
        end else begin
            lfsr_r   <= lfsr_r;
            dnoise_r <= dnoise_r;
        end
    end

    // Feedback filter and audio tap update on every strobe, whatever the state.
    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n) begin
            dfilter_r <= 16'd0;
            q_prev_r  <= 16'd0;
            audio_r   <= 16'd0;
        end else if (sample_en) begin
            dfilter_r <= prod_s[23:8];
            q_prev_r  <= q;
            audio_r   <= q;
        end else begin
            dfilter_r <= dfilter_r;
            q_prev_r  <= q_prev_r;
            audio_r   <= audio_r;
        end
    end

    // Silence run length in RING. Any loud sample restarts it. It saturates at the exit count.
    always_ff @(posedge a_clk or negedge reset_n) begin
        if (!reset_n)                sil_cnt_r <= '0;
        else if (state_r != ST_RING) sil_cnt_r <= '0;
        else if (!sample_en)         sil_cnt_r <= sil_cnt_r;
        else if (!silent_s)          sil_cnt_r <= '0;
        else if (sil_cnt_r != SIL_MAX) sil_cnt_r <= sil_cnt_r + SIL_W'(1);
        else                         sil_cnt_r <= sil_cnt_r;
    end

    assign dnoise    = dnoise_r;
    assign dfilter   = dfilter_r;
    assign audio_out = audio_r;
    assign trigger   = trigger_r;
    assign sclr      = sclr_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_ks_exciter_feedback.sv
// Directed bench for ks_exciter_feedback: filter vectors from a table, plus hand-written
// sequences for reset, bursts, silence timeout and request priority.
module tb_ks_exciter_feedback;

    logic        a_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_en = 1'b0;
    logic        pluck = 1'b0;
    logic        mute = 1'b0;
    logic [7:0]  decay = 8'd0;
    logic [15:0] q = 16'd0;
    logic [15:0] dnoise, dfilter, audio_out;
    logic        trigger, sclr, busy;

    int checks = 0;
    int errors = 0;
    int noise_err = 0;
    logic [15:0] lfsr_m = 16'hACE1;

    ks_exciter_feedback dut (
        .a_clk(a_clk), .reset_n(reset_n), .sample_en(sample_en), .pluck(pluck),
        .mute(mute), .decay(decay), .q(q), .dnoise(dnoise), .dfilter(dfilter),
        .trigger(trigger), .sclr(sclr), .busy(busy), .audio_out(audio_out)
    );

    always #5 a_clk = ~a_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] dec;
        int         qv;
        int         exp_f;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_step(input logic [15:0] l);
        logic lsb;
        lsb = l[0];
        return (l >> 1) ^ (lsb ? 16'hB400 : 16'h0000);
    endfunction

    task automatic strobe(input int qv);
        q = 16'(qv);
        sample_en = 1'b1;
        @(negedge a_clk);
        sample_en = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge a_clk);
    endtask

    task automatic do_pluck();
        pluck = 1'b1;
        @(negedge a_clk);
        pluck = 1'b0;
    endtask

    // Counts the sclr-high cycles seen over a window of n cycles.
    task automatic count_sclr(input int n, output int hits);
        hits = 0;
        repeat (n) begin
            @(negedge a_clk);
            if (sclr) hits++;
        end
    endtask

    // Strobes while trigger is low, with a bound, and compares dnoise against the model.
    task automatic run_burst(input int limit, output int n, output logic [15:0] first);
        logic [15:0] exp_n;
        n = 0;
        first = 16'd0;
        while (trigger == 1'b0 && n < limit) begin
            strobe(0);
            lfsr_m = model_step(lfsr_m);
            exp_n  = 16'($signed(lfsr_m) >>> 1);
            if (n == 0) first = dnoise;
            if (dnoise !== exp_n) noise_err++;
            n++;
        end
    endtask

    initial begin
        int hits;
        int n;
        logic [15:0] first;

        // Hand-computed filter vectors. q_prev is the q of the previous row, starting from 0.
        vecs[0] = '{8'd255, -3,      -2};
        vecs[1] = '{8'd255, 1000,    496};
        vecs[2] = '{8'd255, 1000,    996};
        vecs[3] = '{8'd128, -1000,   0};
        vecs[4] = '{8'd128, -1000,   -500};
        vecs[5] = '{8'd0,   20000,   0};
        vecs[6] = '{8'd200, 32767,   20611};
        vecs[7] = '{8'd255, -32768,  -1};
        vecs[8] = '{8'd255, -32768,  -32640};
        vecs[9] = '{8'd1,   300,     -64};

        // Reset state.
        cycles(3);
        check("rst_trigger", int'(trigger), 1);
        check("rst_sclr", int'(sclr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dnoise", int'(dnoise), 0);
        check("rst_dfilter", int'(dfilter), 0);
        check("rst_audio", int'(audio_out), 0);
        reset_n = 1'b1;
        count_sclr(4, hits);
        check("post_rst_sclr_pulses", hits, 1);
        check("idle_trigger", int'(trigger), 1);
        check("idle_busy", int'(busy), 0);

        // Filter table, applied in IDLE. The datapath is identical in every state.
        for (int i = 0; i < 10; i++) begin
            decay = vecs[i].dec;
            strobe(vecs[i].qv);
            check($sformatf("vec%0d_dfilter", i), int'($signed(dfilter)), vecs[i].exp_f);
            check($sformatf("vec%0d_audio", i), int'($signed(audio_out)), vecs[i].qv);
        end
        check("idle_no_noise", int'(dnoise), 0);

        // First burst from IDLE.
        decay = 8'd0;
        strobe(0);
        do_pluck();
        check("excite_trigger", int'(trigger), 0);
        check("excite_busy", int'(busy), 1);
        run_burst(600, n, first);
        check("burst1_len", n, 512);
        check("burst1_first_noise", int'(first), 32'h0000F138);
        check("ring_trigger", int'(trigger), 1);
        check("ring_busy", int'(busy), 1);

        // Filter in RING.
        decay = 8'd255;
        strobe(1000);
        strobe(1000);
        check("ring_dfilter_996", int'($signed(dfilter)), 996);
        strobe(0);
        strobe(0);
        strobe(-3);
        check("ring_dfilter_m2", int'($signed(dfilter)), -2);

        // Simultaneous pluck and mute in RING: mute wins.
        pluck = 1'b1;
        mute  = 1'b1;
        @(negedge a_clk);
        pluck = 1'b0;
        mute  = 1'b0;
        check("mute_busy", int'(busy), 0);
        check("mute_trigger", int'(trigger), 1);
        count_sclr(4, hits);
        check("mute_sclr_pulses", hits, 1);
        check("mute_idle_busy", int'(busy), 0);

        // Second burst, then a silence timeout interrupted by one loud sample.
        decay = 8'd0;
        strobe(0);
        do_pluck();
        run_burst(600, n, first);
        check("burst2_len", n, 512);
        for (int i = 0; i < 500; i++) strobe(0);
        decay = 8'd255;
        strobe(42);
        check("loud_dfilter", int'($signed(dfilter)), 20);
        decay = 8'd0;
        strobe(0);
        for (int i = 0; i < 1023; i++) strobe(0);
        check("sil_busy_1023", int'(busy), 1);
        strobe(0);
        cycles(2);
        check("sil_busy_1024", int'(busy), 0);
        check("sil_trigger", int'(trigger), 1);

        // Re-pluck at burst count 300: restart without reseed.
        do_pluck();
        for (int i = 0; i < 300; i++) begin
            strobe(0);
            lfsr_m = model_step(lfsr_m);
            if (dnoise !== 16'($signed(lfsr_m) >>> 1)) noise_err++;
        end
        do_pluck();
        check("repluck_trigger", int'(trigger), 0);
        run_burst(600, n, first);
        check("repluck_len", n, 512);
        check("noise_model_mismatches", noise_err, 0);

        // Reset mid-burst reseeds the LFSR.
        do_pluck();
        for (int i = 0; i < 10; i++) strobe(0);
        reset_n = 1'b0;
        cycles(2);
        check("midrst_busy", int'(busy), 0);
        reset_n = 1'b1;
        cycles(3);
        do_pluck();
        strobe(0);
        check("reseed_first_noise", int'(dnoise), 32'h0000F138);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
